// File: rtl/flappy_engine_if.sv
// Bus between the flappy game engine and its controller / display side.
// master drives the game controls and scan column; slave is the engine.
interface flappy_engine_if #(
  parameter int COLS    = 8,
  parameter int ROWS    = 8,
  parameter int LIVES   = 5,
  parameter int SCORE_W = 8
);
  logic                    tick;
  logic                    start;
  logic                    pause;
  logic                    up;
  logic                    down;
  logic [$clog2(COLS)-1:0] scan_col;
  logic [ROWS-1:0]         pipe_col;
  logic [ROWS-1:0]         bird_col;
  logic [LIVES-1:0]        lives;
  logic [SCORE_W-1:0]      score;
  logic [1:0]              state;
  logic                    game_over;

  modport master (
    output tick, start, pause, up, down, scan_col,
    input  pipe_col, bird_col, lives, score, state, game_over
  );

  modport slave (
    input  tick, start, pause, up, down, scan_col,
    output pipe_col, bird_col, lives, score, state, game_over
  );
endinterface

// File: rtl/flappy_engine.sv
// Flappy-bird world state: bird, scrolling pipe slots, lives with grace, score and
// the game FSM, stepped by a tick enable, with a registered column-scan read port.
module flappy_engine #(
  parameter int COLS     = 8,
  parameter int ROWS     = 8,
  parameter int LIVES    = 5,
  parameter int GAP      = 3,
  parameter int SPACING  = 4,
  parameter int BIRD_COL = 2,
  parameter int GRACE    = 3,
  parameter int SCORE_W  = 8
) (
  input  logic             CLK,
  input  logic             clear_n,
  flappy_engine_if.slave   bus
);
  localparam int RW       = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int GW       = (GRACE > 0) ? $clog2(GRACE + 1) : 1;
  localparam int SW       = (SPACING > 1) ? $clog2(SPACING) : 1;
  localparam int GAP_SPAN = ROWS - GAP + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_PLAY  = 2'b01,
    S_PAUSE = 2'b10,
    S_OVER  = 2'b11
  } state_e;

  typedef struct packed {
    logic          valid;
    logic [RW-1:0] gap_top;
  } slot_t;

  state_e             state_q, state_d;
  logic [LIVES-1:0]   lives_q, lives_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [RW-1:0]      bird_q, bird_d;
  logic [GW-1:0]      grace_q, grace_d;
  logic [SW-1:0]      spawn_q, spawn_d;
  logic [7:0]         lfsr_q, lfsr_d;
  slot_t              slot_q [COLS];
  slot_t              slot_d [COLS];
  logic [ROWS-1:0]    pipe_q, pipe_rd;
  logic [ROWS-1:0]    bird_col_q, bird_rd;
  logic [ROWS-1:0]    pipe_here;
  int                 row;

  // A cell is lit when the slot holds a pipe and the row is outside its gap.
  function automatic logic [ROWS-1:0] column_bits(slot_t s);
    logic [ROWS-1:0] bits;
    bits = '0;
    for (int r = 0; r < ROWS; r++)
      bits[r] = s.valid && (r < int'(s.gap_top) || r > int'(s.gap_top) + GAP - 1);
    return bits;
  endfunction

  // NOTE: every variable gets its default before any branch, so no latch is inferred.
  always_comb begin
    state_d   = state_q;
    lives_d   = lives_q;
    score_d   = score_q;
    bird_d    = bird_q;
    grace_d   = grace_q;
    spawn_d   = spawn_q;
    lfsr_d    = lfsr_q;
    slot_d    = slot_q;
    pipe_here = '0;
    row       = 0;

    unique case (state_q)
      S_IDLE:  if (bus.start) state_d = S_PLAY;
      S_PAUSE: if (!bus.pause) state_d = S_PLAY;
      S_OVER: begin
        if (bus.start) begin
          state_d = S_IDLE;
          lives_d = '1;
          score_d = '0;
          bird_d  = RW'(ROWS / 2);
          grace_d = '0;
          spawn_d = '0;
          for (int c = 0; c < COLS; c++) slot_d[c] = '0;
        end
      end
      S_PLAY: begin
        if (bus.pause) begin
          state_d = S_PAUSE;
        end else if (bus.tick) begin
          row = int'(bird_q) + (bus.up ? -1 : 1) + (bus.down ? 1 : 0);
          if (row < 0) row = 0;
          else if (row > ROWS - 1) row = ROWS - 1;
          bird_d = RW'(row);

          if (slot_q[BIRD_COL].valid && score_q != {SCORE_W{1'b1}})
            score_d = score_q + 1'b1;

          for (int c = 0; c < COLS - 1; c++) slot_d[c] = slot_q[c + 1];
          if (spawn_q == SW'(SPACING - 1)) begin
            slot_d[COLS-1].valid   = 1'b1;
            slot_d[COLS-1].gap_top = RW'(lfsr_q % 8'(GAP_SPAN));
            spawn_d                = '0;
          end else begin
            slot_d[COLS-1] = '0;
            spawn_d        = spawn_q + 1'b1;
          end
          lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

          if (grace_q != '0) begin
            grace_d = grace_q - 1'b1;
          end else begin
            pipe_here = column_bits(slot_d[BIRD_COL]);
            if (row == 0 || row == ROWS - 1 || pipe_here[bird_d]) begin
              lives_d                = lives_q << 1;
              slot_d[BIRD_COL].valid = 1'b0;
              grace_d                = GW'(GRACE);
              if (lives_d == '0) state_d = S_OVER;
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Read port: X pattern in OVER, otherwise the addressed slot plus the bird.
  always_comb begin
    pipe_rd = '0;
    bird_rd = '0;
    if (int'(bus.scan_col) < COLS) begin
      if (state_q == S_OVER) begin
        for (int r = 0; r < ROWS; r++)
          pipe_rd[r] = (r == int'(bus.scan_col)) || (r == COLS - 1 - int'(bus.scan_col));
      end else begin
        pipe_rd = column_bits(slot_q[bus.scan_col]);
        if (int'(bus.scan_col) == BIRD_COL) bird_rd[bird_q] = 1'b1;
      end
    end
  end

  // NOTE: sequential state is written only with <= so every flop samples pre-edge values.
  always_ff @(posedge CLK or negedge clear_n) begin
    if (!clear_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_ff @(posedge CLK or negedge clear_n) begin
    if (!clear_n) begin
      lives_q    <= '1;
      score_q    <= '0;
      bird_q     <= RW'(ROWS / 2);
      grace_q    <= '0;
      spawn_q    <= '0;
      lfsr_q     <= 8'hA5;
      pipe_q     <= '0;
      bird_col_q <= '0;
      // NOTE: the slot array is only COLS small registers, so it takes the async reset too.
      for (int c = 0; c < COLS; c++) slot_q[c] <= '0;
    end else begin
      lives_q    <= lives_d;
      score_q    <= score_d;
      bird_q     <= bird_d;
      grace_q    <= grace_d;
      spawn_q    <= spawn_d;
      lfsr_q     <= lfsr_d;
      pipe_q     <= pipe_rd;
      bird_col_q <= bird_rd;
      slot_q     <= slot_d;
    end
  end

  assign bus.pipe_col  = pipe_q;
  assign bus.bird_col  = bird_col_q;
  assign bus.lives     = lives_q;
  assign bus.score     = score_q;
  assign bus.state     = state_q;
  assign bus.game_over = (state_q == S_OVER);
endmodule

// File: doc/flappy_engine.md
# flappy_engine

Parametrised game engine for the flappy-bird LED-matrix design. It holds the whole world state: bird row, a scrolling column map of pipes with random gaps, lives with a post-hit grace window, score, and the game state machine. The engine advances one step per `tick` enable pulse instead of running on derived clocks. A column-scan read port feeds the matrix scanner, and `lives` and `score` feed the LED bar and 7-segment logic.

## Interface
Parameters:
- COLS, 8, matrix columns; pipes scroll from column COLS-1 toward column 0
- ROWS, 8, matrix rows; bird row index 0..ROWS-1, row 0 at top
- LIVES, 5, starting lives; also the width of `lives`
- GAP, 3, gap height in rows; 1 ≤ GAP ≤ ROWS
- SPACING, 4, ticks between pipe spawns; ≥ 1
- BIRD_COL, 2, column the bird occupies; 1 ≤ BIRD_COL < COLS
- GRACE, 3, ticks of hit immunity after a hit
- SCORE_W, 8, score width

Ports:
- CLK  in  1  system clock
- clear_n  in  1  asynchronous, active-low reset
- tick  in  1  one-cycle game-step enable
- start  in  1  start request (IDLE→PLAY, OVER→IDLE)
- pause  in  1  level input; while high, PLAY holds in PAUSE
- up  in  1  flap request, sampled on tick
- down  in  1  dive request, sampled on tick
- scan_col  in  $clog2(COLS)  column to read out
- pipe_col  out  ROWS  pipe or X pixels of scan_col, 1 = lit
- bird_col  out  ROWS  bird pixel of scan_col, 1 = lit
- lives  out  LIVES  thermometer of remaining lives (11111→11110→…→00000)
- score  out  SCORE_W  pipes passed, saturating
- state  out  2  00 IDLE, 01 PLAY, 10 PAUSE, 11 OVER
- game_over  out  1  high while state is OVER

## Operation
- Reset values:
  - state IDLE; lives all ones; score 0; bird row ROWS/2
  - all pipe slots invalid; grace 0; spawn count 0
  - LFSR 8'hA5; pipe_col, bird_col, game_over all 0
- World state:
  - One slot per column, each holding {valid, gap_top}.
  - A cell is lit when its slot is valid and the row lies outside [gap_top, gap_top+GAP-1].
- LFSR: 8-bit Fibonacci, taps x^8+x^6+x^5+x^4+1. It advances once per accepted PLAY tick, after any spawn that tick has used it.
- State transitions:
  - IDLE→PLAY on start. A tick in the same cycle is ignored.
  - PLAY↔PAUSE follows the pause level, evaluated every cycle; ticks are ignored in PAUSE.
  - PLAY→OVER when lives reach 0.
  - OVER→IDLE on start. All world state returns to its reset values except the LFSR, which keeps running.
- Accepted PLAY tick, in order:
  1. Bird move: delta = (up ? −1 : +1) + (down ? +1 : 0). The new row saturates to [0, ROWS−1].
  2. Scroll: each slot c takes the contents of slot c+1.
  3. Score: if the slot leaving BIRD_COL for BIRD_COL−1 is valid, score +1, saturating at 2^SCORE_W−1.
  4. Spawn: slot COLS−1 becomes valid with gap_top = LFSR % (ROWS−GAP+1) when spawn count equals SPACING−1, and spawn count then resets to 0. Otherwise slot COLS−1 is invalid and spawn count increments.
  5. Collision: a hit occurs if the new bird row is 0 or ROWS−1, or if slot BIRD_COL is valid with the bird row outside its gap.
  6. Hit handling, only when grace = 0:
     - lives shift left with a 0 fill at the LSB
     - slot BIRD_COL is invalidated, so a hit pipe is never scored
     - grace is set to GRACE
  7. If grace was nonzero at step 5, no hit is checked and grace decrements.
- Readout:
  - bird_col has the bird row bit set only when scan_col = BIRD_COL and state ≠ OVER.
  - In OVER, pipe_col shows an X: bit r is lit when r = scan_col or r = COLS−1−scan_col, for r < ROWS.
- scan_col ≥ COLS reads all zeros.

## Timing
- Outputs are registered; the read port has 1-cycle latency from scan_col to pipe_col and bird_col.
- All tick effects are visible on lives, score and state in the cycle after the tick, and on the read port one further cycle later.
- Simultaneous cases:
  - start and pause together in IDLE: the engine enters PLAY, then PAUSE on the next cycle.
  - tick on the same cycle pause rises: the tick is ignored.
- clear_n low mid-game: all registers reach their reset values asynchronously; the first tick after release is processed normally.

## Test plan
- Reset, start, 3 ticks with up=0, down=0:
  - bird row goes 4→5→6→7
  - tick 3 hits the floor: lives=11110 and grace=3
- Continue with up=0:
  - ticks 4–6 produce no hit
  - tick 7 hits: lives=11100
  - further hits at ticks 11, 15, 19; after tick 19 lives=00000, state=11 and game_over=1
  - reading scan_col=0 then gives pipe_col=8'b10000001
- Spawn and scroll, with the bird held away from the boundaries (e.g. up on even ticks only):
  - tick 4 spawns a pipe at column 7 with gap_top matching a reference LFSR model mod 6
  - the pipe reaches column 2 at tick 9
- Scoring with GAP=8: with no collisions possible, score=1 after tick 10 and increments every 4 ticks; SCORE_W=2 saturates at 3.
- Dive: from row 4, a tick with down=1 → row 6; a second tick → row 7 (saturated) and a hit.
- Pause and reset:
  - pause=1 in PLAY for 5 ticks leaves all outputs unchanged, with state=10
  - clear_n pulsed low mid-game returns state=00, lives=11111 and score=0
